// File: rtl/relm_ps2_rx.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, deserialises
// 11-bit frames and buffers scancodes in a small FIFO popped by the core.
module relm_ps2_rx #(
    parameter int WD      = 32,
    parameter int WAF     = 4,
    parameter int NFILT   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          rst_n_in,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe_out,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q
);

    localparam int DEPTH = 2 ** WAF;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over the data byte plus the received parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    logic [1:0]       clk_sync_r;
    logic [1:0]       dat_sync_r;
    logic [NFILT-1:0] clk_sh_r;
    logic [NFILT-1:0] dat_sh_r;
    logic             filt_clk_r;
    logic             filt_dat_r;
    logic             filt_clk_d_r;
    logic             fall_s;

    state_t           state_r, state_n;
    logic [2:0]       bit_cnt_r, bit_cnt_n;
    logic [7:0]       shift_r, shift_n;
    logic             par_r, par_n;
    logic [TW-1:0]    tmo_r, tmo_n;
    logic             tmo_hit_s;
    logic             frame_ok_s;
    logic             frame_bad_s;

    logic [7:0]       mem_r [DEPTH];
    logic [WAF:0]     wr_ptr_r;
    logic [WAF:0]     rd_ptr_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_fire_s;
    logic             wr_en_s;
    logic [7:0]       head_s;
    logic             ovf_r;
    logic [7:0]       err_cnt_r;
    logic             oe_r;
    logic             pop_unused_s;

    // Reset is asserted asynchronously but released in step with clk.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Synchronise both pins and only move the filtered level on NFILT agreeing samples.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            clk_sync_r   <= 2'b11;
            dat_sync_r   <= 2'b11;
            clk_sh_r     <= '1;
            dat_sh_r     <= '1;
            filt_clk_r   <= 1'b1;
            filt_dat_r   <= 1'b1;
            filt_clk_d_r <= 1'b1;
        end else begin
            clk_sync_r   <= {clk_sync_r[0], ps2_clk_in};
            dat_sync_r   <= {dat_sync_r[0], ps2_dat_in};
            clk_sh_r     <= {clk_sh_r[NFILT-2:0], clk_sync_r[1]};
            dat_sh_r     <= {dat_sh_r[NFILT-2:0], dat_sync_r[1]};
            filt_clk_d_r <= filt_clk_r;
            if (&clk_sh_r) begin
                filt_clk_r <= 1'b1;
            end else if (~|clk_sh_r) begin
                filt_clk_r <= 1'b0;
            end
            if (&dat_sh_r) begin
                filt_dat_r <= 1'b1;
            end else if (~|dat_sh_r) begin
                filt_dat_r <= 1'b0;
            end
        end
    end
    assign fall_s = filt_clk_d_r & ~filt_clk_r;

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            par_r     <= 1'b0;
            tmo_r     <= '0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            par_r     <= par_n;
            tmo_r     <= tmo_n;
        end
    end

    assign tmo_hit_s = (state_r != ST_IDLE) && !fall_s && (tmo_r == TMO_LIMIT);

    // Next-state logic; a timeout overrides whatever the bit handling decided.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        par_n       = par_r;
        frame_ok_s  = 1'b0;
        frame_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s && !filt_dat_r) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_n   = {filt_dat_r, shift_r[7:1]};
                    bit_cnt_n = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_n   = filt_dat_r;
                    state_n = ST_STOP;
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    if (odd_parity_ok(shift_r, par_r) && filt_dat_r) begin
                        frame_ok_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (tmo_hit_s) begin
            state_n     = ST_IDLE;
            frame_bad_s = 1'b1;
        end else begin
            state_n = state_n;
        end
    end

    // Inactivity counter only runs while a frame is in progress.
    always_comb begin
        tmo_n = tmo_r;
        if ((state_r == ST_IDLE) || fall_s || tmo_hit_s) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo_r + TW'(1);
        end
    end

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[WAF] != rd_ptr_r[WAF]) &&
                        (wr_ptr_r[WAF-1:0] == rd_ptr_r[WAF-1:0]);
    assign pop_fire_s = pop_d[WD] & ~empty_s;
    // A pop in the same cycle frees the slot the completing frame lands in.
    assign wr_en_s    = frame_ok_s & (~full_s | pop_fire_s);
    assign head_s     = mem_r[rd_ptr_r[WAF-1:0]];
    assign pop_unused_s = ^pop_d[WD-1:0];

    // Scancode storage.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r[WAF-1:0]] <= shift_r;
        end
    end

    // FIFO pointers, overflow flag, error counter and clock inhibit.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            ovf_r     <= 1'b0;
            err_cnt_r <= 8'd0;
            oe_r      <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{WAF{1'b0}}, 1'b1};
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + {{WAF{1'b0}}, 1'b1};
                ovf_r    <= 1'b0;
            end else if (frame_ok_s && full_s) begin
                ovf_r <= 1'b1;
            end
            if (frame_bad_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            oe_r <= full_s && (state_r == ST_IDLE);
        end
    end

    assign ps2_clk_oe_out = oe_r;

    // Pop result word assembled from registered state.
    always_comb begin
        pop_q        = '0;
        pop_q[WD]    = empty_s;
        pop_q[23:16] = err_cnt_r;
        pop_q[8]     = ovf_r;
        pop_q[7:0]   = head_s;
    end

endmodule

// File: tb/tb_relm_ps2_rx.sv
// Self-checking bench for relm_ps2_rx: PS/2 frames driven on the pins,
// results compared against a queue-based model of the receive buffer.
module tb_relm_ps2_rx;

    localparam int WD      = 32;
    localparam int WAF     = 4;
    localparam int NFILT   = 8;
    localparam int TIMEOUT = 400;
    localparam int HP      = 20;
    localparam int DEPTH   = 16;

    logic        clk = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic        ps2_clk_oe_out;
    logic [WD:0] pop_d = '0;
    logic [WD:0] pop_q;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    int         m_err = 0;
    bit         m_ovf = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         par_flip;
        bit         stop;
        bit         exp_ok;
    } vec_t;
    vec_t tbl[6];

    relm_ps2_rx #(.WD(WD), .WAF(WAF), .NFILT(NFILT), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n_in      (rst_n_in),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_dat_in    (ps2_dat_in),
        .ps2_clk_oe_out(ps2_clk_oe_out),
        .pop_d         (pop_d),
        .pop_q         (pop_q)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        logic [WD:0] exp;
        logic [WD:0] mask;
        exp = '0;
        mask = '1;
        exp[WD] = (mq.size() == 0);
        exp[23:16] = 8'(m_err);
        exp[8] = m_ovf;
        if (mq.size() != 0) exp[7:0] = mq[0];
        else mask[7:0] = 8'h00;
        cmp({name, ".pop_q"}, 64'(pop_q & mask), 64'(exp & mask));
        cmp({name, ".oe"}, 64'(ps2_clk_oe_out), 64'(mq.size() == DEPTH));
    endtask

    task automatic model_frame(input bit ok, input logic [7:0] d);
        if (ok) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            if (m_err < 255) m_err++;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_dat_in = b;
        repeat (HP) @(posedge clk);
        ps2_clk_in = 1'b0;
        repeat (HP) @(posedge clk);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(((ones % 2) == 0) ^ par_flip);
        send_bit(stop);
        ps2_dat_in = 1'b1;
        repeat (2 * HP) @(posedge clk);
    endtask

    task automatic do_pop(input string name);
        @(negedge clk);
        pop_d = '0;
        pop_d[WD] = 1'b1;
        #1;
        check_all(name);
        @(posedge clk);
        #1;
        pop_d = '0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        while (mq.size() != 0) do_pop(name);
        check_all({name, ".empty"});
    endtask

    initial begin
        bit   ok;
        int   ones;
        logic [7:0] d;
        bit   pf, st;

        tbl[0] = '{8'h00, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{8'h7E, 1'b1, 1'b0, 1'b0};

        repeat (5) @(posedge clk);
        rst_n_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all("reset");

        // Basic frame and a pop from empty afterwards.
        send_frame(8'h1C, 1'b0, 1'b1);
        model_frame(1'b1, 8'h1C);
        check_all("f1c");
        do_pop("f1c.pop");
        check_all("f1c.after");
        do_pop("empty.pop");
        check_all("empty.after");

        // Parity error then valid frame.
        send_frame(8'hF0, 1'b1, 1'b1);
        model_frame(1'b0, 8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1);
        model_frame(1'b1, 8'h1C);
        check_all("parerr");
        drain("parerr");

        // Partial frame aborted by the inactivity timeout.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_dat_in = 1'b1;
        repeat (TIMEOUT + 50) @(posedge clk);
        model_frame(1'b0, 8'h00);
        send_frame(8'h29, 1'b0, 1'b1);
        model_frame(1'b1, 8'h29);
        check_all("timeout");
        drain("timeout");

        // Fill FIFO, overflow the 17th, then drain.
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            model_frame(1'b1, 8'(i));
            check_all($sformatf("fill%0d", i));
        end
        do_pop("fill.pop1");
        check_all("fill.after1");
        drain("fill");

        // Short clock glitches while idle must not start a frame.
        for (int i = 0; i < 6; i++) begin
            ps2_clk_in = 1'b0;
            repeat (3) @(posedge clk);
            ps2_clk_in = 1'b1;
            repeat (12) @(posedge clk);
        end
        #1;
        check_all("glitch");
        send_frame(8'h33, 1'b0, 1'b1);
        model_frame(1'b1, 8'h33);
        check_all("glitch.frame");
        drain("glitch");

        // Table of fixed frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].par_flip, tbl[i].stop);
            model_frame(tbl[i].exp_ok, tbl[i].data);
            check_all($sformatf("tbl%0d", i));
        end
        drain("tbl");

        // Randomised frames with occasional corruption and interleaved pops.
        for (int i = 0; i < 30; i++) begin
            d  = 8'($urandom_range(0, 255));
            pf = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) != 0);
            ones = 0;
            for (int b = 0; b < 8; b++) ones += int'(d[b]);
            ok = (((ones + ((((ones % 2) == 0) ^ pf) ? 1 : 0)) % 2) == 1) && st;
            send_frame(d, pf, st);
            model_frame(ok, d);
            check_all($sformatf("rnd%0d", i));
            if ((mq.size() >= 12) || ($urandom_range(0, 2) == 0)) do_pop($sformatf("rnd%0d.pop", i));
        end
        drain("rnd");

        // Reset in the middle of a frame.
        send_frame(8'h44, 1'b0, 1'b1);
        model_frame(1'b1, 8'h44);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        ps2_dat_in = 1'b1;
        rst_n_in = 1'b0;
        #1;
        mq.delete();
        m_err = 0;
        m_ovf = 1'b0;
        check_all("midrst.during");
        repeat (4) @(posedge clk);
        rst_n_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all("midrst.after");
        send_frame(8'h5A, 1'b0, 1'b1);
        model_frame(1'b1, 8'h5A);
        check_all("midrst.5a");
        drain("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relm_ps2_rx.md
Name: relm_ps2_rx

Overview:
- Hardware PS/2 keyboard receiver. It replaces CPU bit-banging of the PS/2 clock/data lines with frame deserialisation and a small scancode FIFO.
- It sits directly upstream of the relm core and connects to one pop channel of the core's pop bus. Each CPU pop returns one scancode, or a retry when nothing is buffered.
- Receive-only. Host-to-device commands stay out of scope; the block's only drive onto the bus is inhibiting the PS/2 clock line when its FIFO is full.

Parameters:
- WD, 32, CPU data width; pop bus words are WD+1 bits.
- WAF, 4, log2 of FIFO depth (16 entries).
- NFILT, 8, glitch-filter length in samples.
- TIMEOUT, 100000, clocks without a PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz).

Ports:
- clk, in, 1: system clock (50 MHz).
- rst_n_in, in, 1: asynchronous active-low reset.
- ps2_clk_in, in, 1: raw PS/2 clock pin level.
- ps2_dat_in, in, 1: raw PS/2 data pin level.
- ps2_clk_oe_out, out, 1: 1 = drive PS/2 clock low (inhibit); top level converts this to 1'b0/1'bz.
- pop_d, in, WD+1: pop channel from core; bit WD = pop strobe, other bits ignored.
- pop_q, out, WD+1: pop result to core. Bit WD = retry (FIFO empty). [7:0] = head scancode. [8] = overflow sticky. [23:16] = frame error count. All other bits 0.

Behaviour:
- Reset (async assert, sync deassert internally):
  - FIFO empty; FSM in IDLE; error count 0; overflow 0.
  - Filters preset to 1.
  - ps2_clk_oe_out=0; pop_q[WD]=1.
- Input conditioning:
  - 2-flop synchroniser per line, then an NFILT-deep shift register.
  - The filtered level changes only when all NFILT samples agree; otherwise it holds.
  - Falling edge = filtered clock 1->0. It is detected one clock after the filter flips and is a 1-cycle pulse.
- Sampling: data is sampled from the filtered data level on each falling-edge pulse.
- FSM transitions:
  - IDLE: on falling edge with data=0 (start bit) -> DATA, bit count=0. Falling edge with data=1 is ignored.
  - DATA: shift LSB-first into an 8-bit shift register; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on edge, the frame is valid iff odd parity holds over data+parity AND stop=1.
    - Valid and FIFO not full: write the scancode to FIFO.
    - Valid and FIFO full: drop the scancode and set overflow.
    - Invalid: discard and increment the error count.
    - In every case -> IDLE.
- Timeout:
  - Counter cleared on each falling edge and in IDLE.
  - If it reaches TIMEOUT in any non-IDLE state: -> IDLE, partial frame discarded, error count incremented.
- Error count: 8-bit and saturates at 255.
- FIFO: 2**WAF entries × 8 bits, with WAF+1-bit read/write pointers.
  - empty = pointers equal; full = MSBs differ and the rest are equal.
  - Pointers wrap naturally.
- pop_q timing:
  - pop_q is combinational from registered state: head entry, overflow, error count, empty.
  - The core samples it in the cycle it asserts the strobe.
- Pop strobe:
  - pop_d[WD]=1 and !empty: read pointer advances at the clock edge and overflow clears.
  - pop_d[WD]=1 and empty: no state change; the core sees retry=1 and retries.
- Simultaneous pop and push in one cycle:
  - Both take effect. Count is unchanged.
  - When full, a pop and a completing frame in the same cycle: the write succeeds and overflow is not set.
- Inhibit:
  - ps2_clk_oe_out registered, =1 when the FIFO is full and FSM is IDLE. A frame already in progress is never cut.
  - Released the cycle after a pop makes the FIFO non-full.
- Reset mid-frame: everything returns to reset values immediately. No partial scancode is ever written.

Test Plan:
- Reset, then send frame 0x1C (start 0, bits 0011_1000 LSB-first, parity 0, stop 1) at 12.5 kHz. Required: pop_q[WD]=0, pop_q[7:0]=0x1C, error count=0. After one pop, pop_q[WD]=1.
- Send 0xF0 with wrong parity bit, then a valid 0x1C. Required: error count=1 and FIFO holds only 0x1C.
- Send start+3 data bits, then idle 2 ms + 10 clocks, then valid 0x29. Required: error count=1; FIFO holds 0x29 only.
- Send 17 valid frames 0x01..0x11 with no pops. Required:
  - ps2_clk_oe_out=1 after the 16th frame.
  - 17th frame (sent forcing the clock) is dropped and pop_q[8]=1.
  - Pops return 0x01..0x10; overflow clears after the first pop; oe drops after the first pop.
- Inject 3-clock glitches (shorter than NFILT) on ps2_clk_in while idle. Required: no FSM activity and no errors.
- Assert rst_n_in after 5 data bits. Required: no FIFO write. A subsequent valid 0x5A is received correctly.
